// File: rtl/dead_time_pkg.sv
// Shared definitions for the dead-time generator: leg state encoding and output decode helpers.
package dead_time_pkg;

  localparam int NUM_LEGS = 3;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    HS_ON = 2'd1,
    LS_ON = 2'd2,
    DEAD  = 2'd3
  } leg_state_e;

  // Gate decode: only one conducting state per side, so the two can never be high together.
  function automatic logic leg_hs(leg_state_e s);
    return (s == HS_ON);
  endfunction

  function automatic logic leg_ls(leg_state_e s);
    return (s == LS_ON);
  endfunction

endpackage

// File: rtl/dead_time_gen_if.sv
// Control and gate-drive bundle between the SPWM controller (master) and the dead-time stage (slave).
interface dead_time_gen_if #(
  parameter int DT_W = 8
);
  import dead_time_pkg::*;

  logic                en;
  logic [DT_W-1:0]     dead_time;
  logic [NUM_LEGS-1:0] pwm_in;
  logic                fault_n;
  logic                fault_clr;
  logic [NUM_LEGS-1:0] hs_out;
  logic [NUM_LEGS-1:0] ls_out;
  logic                fault_latched;

  modport master (
    output en,
    output dead_time,
    output pwm_in,
    output fault_n,
    output fault_clr,
    input  hs_out,
    input  ls_out,
    input  fault_latched
  );

  modport slave (
    input  en,
    input  dead_time,
    input  pwm_in,
    input  fault_n,
    input  fault_clr,
    output hs_out,
    output ls_out,
    output fault_latched
  );

endinterface

// File: rtl/dead_time_gen_leg.sv
// One inverter leg: OFF/HS_ON/LS_ON/DEAD state machine, dead-interval counter and registered gate enables.
module dt_leg
  import dead_time_pkg::*;
#(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic [DT_W-1:0] dead_time,
  input  logic            pwm,
  output logic            hs,
  output logic            ls
);

  leg_state_e      state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            hs_q, hs_d;
  logic            ls_q, ls_d;
  logic [DT_W-1:0] dt_eff;

  // A programmed zero still yields one dead cycle.
  assign dt_eff = (dead_time == '0) ? DT_W'(1) : dead_time;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (kill) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF: begin
          state_d = DEAD;
          cnt_d   = dt_eff;
        end
        HS_ON: begin
          if (!pwm) begin
            state_d = DEAD;
            cnt_d   = dt_eff;
          end
        end
        LS_ON: begin
          if (pwm) begin
            state_d = DEAD;
            cnt_d   = dt_eff;
          end
        end
        DEAD: begin
          // Exit target is whatever pwm says at expiry; toggles inside the interval are ignored.
          if (cnt_q == DT_W'(1)) begin
            state_d = pwm ? HS_ON : LS_ON;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        default: state_d = OFF;
      endcase
    end
    hs_d = leg_hs(state_d);
    ls_d = leg_ls(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hs_q    <= hs_d;
      ls_q    <= ls_d;
    end
  end

  assign hs = hs_q;
  assign ls = ls_q;

endmodule

// File: rtl/dead_time_gen.sv
// Three-leg complementary gate driver with programmable dead time, enable and latched fault trip.
module dead_time_gen
  import dead_time_pkg::*;
#(
  parameter int DT_W     = 8,
  parameter int FLT_SYNC = 2
) (
  input  logic            clk,
  input  logic            rst,
  dead_time_gen_if.slave  bus
);

  logic [NUM_LEGS-1:0] pwm_q, pwm_d;
  logic [FLT_SYNC-1:0] sync_q, sync_d;
  logic                fault_latched_q, fault_latched_d;
  logic                fault_s;
  logic                kill;
  logic [NUM_LEGS-1:0] hs_w;
  logic [NUM_LEGS-1:0] ls_w;

  assign fault_s = sync_q[FLT_SYNC-1];

  // The live synchronised fault is included so legs drop on the same edge the latch sets.
  assign kill = fault_latched_q | ~fault_s | ~bus.en;

  always_comb begin
    pwm_d  = bus.pwm_in;
    sync_d = {sync_q[FLT_SYNC-2:0], bus.fault_n};
    fault_latched_d = fault_latched_q;
    if (!fault_s) begin
      fault_latched_d = 1'b1;
    end else if (bus.fault_clr) begin
      fault_latched_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q           <= '0;
      sync_q          <= '1;
      fault_latched_q <= 1'b0;
    end else begin
      pwm_q           <= pwm_d;
      sync_q          <= sync_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LEGS; gi++) begin : g_leg
      dt_leg #(
        .DT_W (DT_W)
      ) u_leg (
        .clk       (clk),
        .rst       (rst),
        .kill      (kill),
        .dead_time (bus.dead_time),
        .pwm       (pwm_q[gi]),
        .hs        (hs_w[gi]),
        .ls        (ls_w[gi])
      );
    end
  endgenerate

  assign bus.hs_out        = hs_w;
  assign bus.ls_out        = ls_w;
  assign bus.fault_latched = fault_latched_q;

endmodule
